hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_FREEZE = 1'b1
    } state_t;

    localparam int CNT_WIDTH     = 32;
    localparam int REG_IDX_WIDTH = 5;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: cache freeze, branch flush (deferred across
// freezes) and load-use stall, plus saturating performance counters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   S_RUN    | pipeline advancing; pend_flush is always clear here
//   S_FREEZE | a cache miss held the pipeline last cycle
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_IDX_WIDTH-1:0] IF_ID_RegisterRs1,
    input  logic [REG_IDX_WIDTH-1:0] IF_ID_RegisterRs2,
    input  logic                     ID_EX_MemRead,
    input  logic [REG_IDX_WIDTH-1:0] ID_EX_RegisterRd,
    input  logic                     EX_branch_taken,
    input  logic                     icache_stall,
    input  logic                     dcache_stall,
    input  logic                     perf_clr,
    output logic                     PC_stall,
    output logic                     IF_ID_stall,
    output logic                     ID_EX_stall,
    output logic                     EX_MEM_stall,
    output logic                     MEM_WB_stall,
    output logic                     IF_ID_flush,
    output logic                     ID_EX_flush,
    output logic [CNT_WIDTH-1:0]     cycle_cnt,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     flush_cnt
);

    state_t state_q, state_d;
    logic   pend_flush_q, pend_flush_d;
    logic   freeze, flush_now, load_use, lu_stall;

    assign freeze    = icache_stall | dcache_stall;
    assign flush_now = ~freeze & (EX_branch_taken | pend_flush_q);
    assign load_use  = ID_EX_MemRead
                     & (ID_EX_RegisterRd != '0)
                     & ((ID_EX_RegisterRd == IF_ID_RegisterRs1)
                      | (ID_EX_RegisterRd == IF_ID_RegisterRs2));
    assign lu_stall  = load_use & ~freeze & ~flush_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    // A branch resolved during a freeze is remembered and replayed on the
    // first cycle the pipeline moves again.
    always_comb begin
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        case (state_q)
            S_RUN: begin
                if (freeze) begin
                    state_d      = S_FREEZE;
                    pend_flush_d = pend_flush_q | EX_branch_taken;
                end
            end
            S_FREEZE: begin
                if (freeze) begin
                    pend_flush_d = pend_flush_q | EX_branch_taken;
                end else begin
                    state_d      = S_RUN;
                    pend_flush_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_RUN;
                pend_flush_d = 1'b0;
            end
        endcase
    end

    // Stalls track the live freeze input so a miss holds the pipe with no delay.
    always_comb begin
        PC_stall     = freeze | lu_stall;
        IF_ID_stall  = freeze | lu_stall;
        ID_EX_stall  = freeze;
        EX_MEM_stall = freeze;
        MEM_WB_stall = freeze;
        IF_ID_flush  = flush_now;
        ID_EX_flush  = flush_now | lu_stall;
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .clr   (perf_clr),
        .count (cycle_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze | lu_stall),
        .clr   (perf_clr),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_now),
        .clr   (perf_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors, corner sequences and
// random stimulus against a rule-level reference model.
module tb_hazard_ctrl;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       memread;
        logic       br;
        logic       ic;
        logic       dc;
        logic       clr;
        logic       rst;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [6:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IF_ID_RegisterRs1, IF_ID_RegisterRs2, ID_EX_RegisterRd;
    logic        ID_EX_MemRead, EX_branch_taken, icache_stall, dcache_stall, perf_clr;
    logic        PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
    logic        IF_ID_flush, ID_EX_flush;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    logic        sc_inc = 1'b0;
    logic        sc_clr = 1'b0;
    logic [2:0]  sc_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic        m_pend;
    logic [31:0] m_cyc, m_stall, m_flush;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .IF_ID_RegisterRs1 (IF_ID_RegisterRs1),
        .IF_ID_RegisterRs2 (IF_ID_RegisterRs2),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegisterRd  (ID_EX_RegisterRd),
        .EX_branch_taken   (EX_branch_taken),
        .icache_stall      (icache_stall),
        .dcache_stall      (dcache_stall),
        .perf_clr          (perf_clr),
        .PC_stall          (PC_stall),
        .IF_ID_stall       (IF_ID_stall),
        .ID_EX_stall       (ID_EX_stall),
        .EX_MEM_stall      (EX_MEM_stall),
        .MEM_WB_stall      (MEM_WB_stall),
        .IF_ID_flush       (IF_ID_flush),
        .ID_EX_flush       (ID_EX_flush),
        .cycle_cnt         (cycle_cnt),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    sat_counter #(.WIDTH(3)) u_sat3 (
        .clk   (clk),
        .rst   (rst),
        .inc   (sc_inc),
        .clr   (sc_clr),
        .count (sc_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input bit en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    // Rule-level model: classify the cycle, then derive outputs by priority.
    function automatic logic [6:0] model_outs(input stim_t s, input logic pend,
                                              output bit frz, output bit fl, output bit lus);
        bit lu;
        frz = s.ic || s.dc;
        fl  = !frz && (s.br || pend);
        lu  = s.memread && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2);
        lus = lu && !frz && !fl;
        if (frz)      return 7'b11111_00;
        else if (fl)  return 7'b00000_11;
        else if (lus) return 7'b11000_01;
        else          return 7'b00000_00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, memread: 1'b0, br: 1'b0,
              ic: 1'b0, dc: 1'b0, clr: 1'b0, rst: 1'b0};
        return s;
    endfunction

    // One cycle: drive after the falling edge, check before the rising edge,
    // then advance the model across the rising edge.
    task automatic run_cycle(input stim_t s, input string nm,
                             input bit use_tab, input logic [6:0] texp);
        logic [6:0] mexp, act;
        bit frz, fl, lus;
        rst               = s.rst;
        IF_ID_RegisterRs1 = s.rs1;
        IF_ID_RegisterRs2 = s.rs2;
        ID_EX_RegisterRd  = s.rd;
        ID_EX_MemRead     = s.memread;
        EX_branch_taken   = s.br;
        icache_stall      = s.ic;
        dcache_stall      = s.dc;
        perf_clr          = s.clr;
        if (s.rst) begin
            m_pend = 1'b0; m_cyc = '0; m_stall = '0; m_flush = '0;
        end
        #1;
        mexp = model_outs(s, m_pend, frz, fl, lus);
        act  = {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
                IF_ID_flush, ID_EX_flush};
        chk({nm, " outs"}, {25'd0, act}, {25'd0, use_tab ? texp : mexp});
        chk({nm, " cycle_cnt"}, cycle_cnt, m_cyc);
        chk({nm, " stall_cnt"}, stall_cnt, m_stall);
        chk({nm, " flush_cnt"}, flush_cnt, m_flush);
        @(posedge clk);
        if (!s.rst) begin
            if (s.clr) begin
                m_cyc = '0; m_stall = '0; m_flush = '0;
            end else begin
                m_cyc   = sat_inc(m_cyc, 1'b1);
                m_stall = sat_inc(m_stall, frz || lus);
                m_flush = sat_inc(m_flush, fl);
            end
            m_pend = frz ? (m_pend || s.br) : 1'b0;
        end
        @(negedge clk);
    endtask

    vec_t  tab[$];
    stim_t s;
    int    frz_left;

    initial begin
        s = idle();
        s.rst = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        run_cycle(s, "reset", 1'b1, 7'b0);
        run_cycle(s, "reset hold", 1'b1, 7'b0);

        s = idle(); s.memread = 1; s.rd = 5; s.rs1 = 1; s.rs2 = 5;
        tab.push_back('{"load_use rs2", s, 7'b11000_01});
        s = idle(); s.memread = 1; s.rd = 0; s.rs1 = 0; s.rs2 = 0;
        tab.push_back('{"x0 guard", s, 7'b00000_00});
        s = idle(); s.memread = 1; s.rd = 7; s.rs1 = 7; s.rs2 = 2;
        tab.push_back('{"load_use rs1", s, 7'b11000_01});
        s = idle(); s.memread = 0; s.rd = 7; s.rs1 = 7; s.rs2 = 7;
        tab.push_back('{"no memread", s, 7'b00000_00});
        s = idle(); s.memread = 1; s.rd = 9; s.rs1 = 9; s.br = 1;
        tab.push_back('{"branch+load_use", s, 7'b00000_11});
        s = idle(); s.br = 1;
        tab.push_back('{"branch", s, 7'b00000_11});
        s = idle(); s.memread = 1; s.rd = 4; s.rs2 = 4; s.ic = 1;
        tab.push_back('{"icache+load_use", s, 7'b11111_00});
        s = idle(); s.dc = 1;
        tab.push_back('{"dcache", s, 7'b11111_00});
        s = idle(); s.memread = 1; s.rd = 3; s.rs1 = 1; s.rs2 = 2;
        tab.push_back('{"no match", s, 7'b00000_00});
        s = idle();
        tab.push_back('{"idle", s, 7'b00000_00});
        foreach (tab[i]) run_cycle(tab[i].s, tab[i].name, 1'b1, tab[i].exp);

        // Deferred flush: dcache miss for 4 cycles, branch resolves in cycle 2.
        s = idle(); s.clr = 1;
        run_cycle(s, "clr", 1'b0, 7'b0);
        for (int c = 1; c <= 4; c++) begin
            s = idle(); s.dc = 1; s.br = (c == 2);
            run_cycle(s, $sformatf("deferred c%0d", c), 1'b1, 7'b11111_00);
        end
        s = idle();
        run_cycle(s, "deferred c5", 1'b1, 7'b00000_11);
        run_cycle(s, "deferred c6", 1'b1, 7'b00000_00);
        chk("deferred flush_cnt", flush_cnt, 32'd1);
        chk("deferred stall_cnt", stall_cnt, 32'd4);

        // Reset during a freeze with a flush pending must drop the flush.
        s = idle(); s.dc = 1;
        run_cycle(s, "rstfrz c1", 1'b1, 7'b11111_00);
        s.br = 1;
        run_cycle(s, "rstfrz c2", 1'b1, 7'b11111_00);
        s.br = 0; s.rst = 1;
        run_cycle(s, "rstfrz rst", 1'b1, 7'b11111_00);
        s = idle();
        run_cycle(s, "rstfrz release", 1'b1, 7'b00000_00);
        run_cycle(s, "rstfrz after", 1'b1, 7'b00000_00);

        // Randomized traffic against the model.
        frz_left = 0;
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.rs1     = 5'($urandom_range(0, 3));
            s.rs2     = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 3));
            s.memread = ($urandom_range(0, 1) == 0);
            s.br      = ($urandom_range(0, 5) == 0);
            s.ic      = ($urandom_range(0, 11) == 0);
            if (frz_left > 0) begin
                s.dc = 1; frz_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                s.dc = 1; frz_left = $urandom_range(0, 4);
            end
            s.clr = ($urandom_range(0, 49) == 0);
            s.rst = ($urandom_range(0, 149) == 0);
            run_cycle(s, $sformatf("rand%0d", n), 1'b0, 7'b0);
        end

        // Saturation and clear priority on a narrow instance of the counter.
        s = idle();
        sc_clr = 1;
        run_cycle(s, "sat pre", 1'b0, 7'b0);
        sc_clr = 0; sc_inc = 1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("sat count k%0d", k), {29'd0, sc_count}, (k > 7) ? 32'd7 : k);
            run_cycle(s, "sat", 1'b0, 7'b0);
        end
        sc_clr = 1;
        run_cycle(s, "sat clr", 1'b0, 7'b0);
        chk("sat clr over inc", {29'd0, sc_count}, 32'd0);
        sc_clr = 0; sc_inc = 0;
        run_cycle(s, "sat idle", 1'b0, 7'b0);
        chk("sat hold", {29'd0, sc_count}, 32'd0);

        // Top-level perf_clr zeroes all counters on the next edge.
        s = idle(); s.dc = 1;
        run_cycle(s, "pclr pre", 1'b0, 7'b0);
        s = idle(); s.clr = 1; s.br = 1;
        run_cycle(s, "pclr", 1'b0, 7'b0);
        s = idle();
        run_cycle(s, "pclr after", 1'b0, 7'b0);
        chk("pclr cycle_cnt", cycle_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
